// File: rtl/unary_add_ctrl.sv
// Sequencer for a unary-counter adder: streams operands as pulse trains into the
// datapath counter, then drains it back to binary while tracking the carry-out.
module unary_add_ctrl #(
    parameter int W = 15
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] opa,
    input  logic [W-1:0] opb,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] sum,
    output logic         ovf,
    output logic         dp_en,
    output logic         dp_row,
    output logic         dp_a,
    output logic         dp_b,
    input  logic         dp_dout,
    input  logic         dp_c
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_FLUSH = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam logic [W-1:0] ZERO_W = {W{1'b0}};
    localparam logic [W-1:0] ONE_W  = {{(W-1){1'b0}}, 1'b1};

    // Pulse-budget countdown: a nonzero budget emits one pulse and shrinks by one.
    function automatic logic [W-1:0] step_down(input logic [W-1:0] val);
        logic [W-1:0] res;
        if (val != ZERO_W) begin
            res = val - ONE_W;
        end else begin
            res = val;
        end
        return res;
    endfunction

    state_t       state_r, state_s;
    logic [W-1:0] ra_r, ra_s;
    logic [W-1:0] rb_r, rb_s;
    logic [W-1:0] sum_r, sum_s;
    logic         ovf_r, ovf_s;
    logic         wr_first_r, wr_first_s;
    logic         busy_r, busy_s;
    logic         done_r, done_s;
    logic         dp_en_r, dp_en_s;
    logic         dp_row_r, dp_row_s;
    logic         dp_a_r, dp_a_s;
    logic         dp_b_r, dp_b_s;

    // Next-state, datapath bookkeeping and next values of every registered output.
    always_comb begin
        state_s    = state_r;
        ra_s       = ra_r;
        rb_s       = rb_r;
        sum_s      = sum_r;
        ovf_s      = ovf_r;
        wr_first_s = wr_first_r;

        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    ra_s    = opa;
                    rb_s    = opb;
                    sum_s   = ZERO_W;
                    ovf_s   = 1'b0;
                    state_s = ST_READ;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_READ: begin
                ra_s = step_down(ra_r);
                rb_s = step_down(rb_r);
                if (dp_c) begin
                    ovf_s = 1'b1;
                end else begin
                    ovf_s = ovf_r;
                end
                if ((ra_r <= ONE_W) && (rb_r <= ONE_W)) begin
                    state_s = ST_FLUSH;
                end else begin
                    state_s = ST_READ;
                end
            end
            ST_FLUSH: begin
                // The carry from the last READ add only becomes visible here.
                if (dp_c) begin
                    ovf_s = 1'b1;
                end else begin
                    ovf_s = ovf_r;
                end
                wr_first_s = 1'b1;
                state_s    = ST_WRITE;
            end
            ST_WRITE: begin
                if (wr_first_r) begin
                    wr_first_s = 1'b0;
                end else if (dp_dout) begin
                    sum_s = sum_r + ONE_W;
                end else begin
                    state_s = ST_DONE;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase

        busy_s   = (state_s != ST_IDLE);
        done_s   = (state_s == ST_DONE);
        dp_en_s  = (state_s == ST_READ) || (state_s == ST_WRITE);
        dp_row_s = (state_s == ST_WRITE);
        dp_a_s   = (state_s == ST_READ) && (ra_s != ZERO_W);
        dp_b_s   = (state_s == ST_READ) && (rb_s != ZERO_W);
    end

    // State and output registers; synchronous reset overrides every transition.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            ra_r       <= ZERO_W;
            rb_r       <= ZERO_W;
            sum_r      <= ZERO_W;
            ovf_r      <= 1'b0;
            wr_first_r <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            dp_en_r    <= 1'b0;
            dp_row_r   <= 1'b0;
            dp_a_r     <= 1'b0;
            dp_b_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            ra_r       <= ra_s;
            rb_r       <= rb_s;
            sum_r      <= sum_s;
            ovf_r      <= ovf_s;
            wr_first_r <= wr_first_s;
            busy_r     <= busy_s;
            done_r     <= done_s;
            dp_en_r    <= dp_en_s;
            dp_row_r   <= dp_row_s;
            dp_a_r     <= dp_a_s;
            dp_b_r     <= dp_b_s;
        end
    end

    assign busy   = busy_r;
    assign done   = done_r;
    assign sum    = sum_r;
    assign ovf    = ovf_r;
    assign dp_en  = dp_en_r;
    assign dp_row = dp_row_r;
    assign dp_a   = dp_a_r;
    assign dp_b   = dp_b_r;

endmodule
